instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 83 ++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: prefetching fetch stage; issues sequential word fetches and buffers {data, pc} in a FIFO.
// Redirects flush the buffer and discard responses still in flight.
module instr_fetch_unit #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   pc_q   [FIFO_DEPTH];
    logic [CW:0]   credit;
    logic [31:0]   redirect_tgt;
    logic          req_fire, resp_fire, dropping, push, pop;

    always_comb begin
        redirect_tgt  = redirect_pc & 32'hFFFF_FFFC;
        // buffered plus in-flight words never exceed the FIFO, so every response has a slot
        credit        = {1'b0, count_q} + {1'b0, outstanding_q};
        mem_req_valid = reset & ~redirect_valid & (credit < (CW+1)'(FIFO_DEPTH));
        mem_req_addr  = fetch_pc_q;
        instr_valid   = reset & (count_q != '0);
        instr_data    = data_q[rd_ptr_q];
        instr_pc      = pc_q[rd_ptr_q];
        req_fire      = mem_req_valid & mem_req_ready;
        resp_fire     = mem_resp_valid & (outstanding_q != '0);
        dropping      = drop_cnt_q != '0;
        push          = resp_fire & ~dropping & ~redirect_valid;
        pop           = instr_valid & instr_ready & ~redirect_valid;
        fetch_pc_d    = redirect_valid ? redirect_tgt : fetch_pc_q + (req_fire ? 32'd4 : 32'd0);
        resp_pc_d     = redirect_valid ? redirect_tgt : resp_pc_q + (push ? 32'd4 : 32'd0);
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_fire);
        drop_cnt_d    = redirect_valid ? outstanding_q - CW'(resp_fire)
                                       : drop_cnt_q - CW'(resp_fire & dropping);
        count_d       = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = redirect_valid ? wr_ptr_q : rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            data_q[wr_ptr_q] <= mem_resp_data;
            pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end
endmodule
